// File: rtl/ddr_burst_arb.sv
// Round-robin arbiter sharing one DDR burst port among four sources: the
// write and read channels of two clients. Each burst is bounded by a watchdog.
module ddr_burst_arb #(
  parameter int          DDR_ADDR_WD = 32,
  parameter int          DDR_DATA_WD = 512,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic                   ddr_clk,
  input  logic                   ddr_rst,
  input  logic                   cfg_arb_en,
  output logic [1:0]             sts_grant_idx,
  output logic                   sts_busy,
  output logic [15:0]            sts_timeout_cnt,

  input  logic                   c0_wr_burst_req,
  input  logic [9:0]             c0_wr_burst_len,
  input  logic [DDR_ADDR_WD-1:0] c0_wr_burst_addr,
  input  logic [DDR_DATA_WD-1:0] c0_wr_burst_data,
  output logic                   c0_wr_burst_data_req,
  output logic                   c0_wr_burst_finish,
  input  logic                   c0_rd_burst_req,
  input  logic [9:0]             c0_rd_burst_len,
  input  logic [DDR_ADDR_WD-1:0] c0_rd_burst_addr,
  output logic                   c0_rd_burst_data_valid,
  output logic [DDR_DATA_WD-1:0] c0_rd_burst_data,
  output logic                   c0_rd_burst_finish,

  input  logic                   c1_wr_burst_req,
  input  logic [9:0]             c1_wr_burst_len,
  input  logic [DDR_ADDR_WD-1:0] c1_wr_burst_addr,
  input  logic [DDR_DATA_WD-1:0] c1_wr_burst_data,
  output logic                   c1_wr_burst_data_req,
  output logic                   c1_wr_burst_finish,
  input  logic                   c1_rd_burst_req,
  input  logic [9:0]             c1_rd_burst_len,
  input  logic [DDR_ADDR_WD-1:0] c1_rd_burst_addr,
  output logic                   c1_rd_burst_data_valid,
  output logic [DDR_DATA_WD-1:0] c1_rd_burst_data,
  output logic                   c1_rd_burst_finish,

  output logic                   wr_burst_req,
  output logic [9:0]             wr_burst_len,
  output logic [DDR_ADDR_WD-1:0] wr_burst_addr,
  output logic [DDR_DATA_WD-1:0] wr_burst_data,
  input  logic                   wr_burst_data_req,
  input  logic                   wr_burst_finish,
  output logic                   rd_burst_req,
  output logic [9:0]             rd_burst_len,
  output logic [DDR_ADDR_WD-1:0] rd_burst_addr,
  input  logic                   rd_burst_data_valid,
  input  logic [DDR_DATA_WD-1:0] rd_burst_data,
  input  logic                   rd_burst_finish
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [1:0]             grant_idx;
  logic [9:0]             len_q;
  logic [DDR_ADDR_WD-1:0] addr_q;
  logic [15:0]            wdog;
  logic                   wr_act;
  logic                   rd_act;
  logic                   zero_fin;

  logic [3:0]             req;
  logic [3:0]             hit;
  logic [1:0]             cand;
  logic [1:0]             next_idx;
  logic                   grant_found;
  logic [9:0]             sel_len;
  logic [DDR_ADDR_WD-1:0] sel_addr;
  logic                   fin_match;

  assign req = {c1_rd_burst_req, c1_wr_burst_req, c0_rd_burst_req, c0_wr_burst_req};

  // NOTE: every variable gets a default before the loop so no path infers a latch.
  always_comb begin
    next_idx    = sts_grant_idx;
    grant_found = 1'b0;
    cand        = sts_grant_idx;
    for (int i = 1; i <= 4; i++) begin
      cand = sts_grant_idx + 2'(i);
      if (!grant_found && req[cand]) begin
        next_idx    = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_len  = c0_wr_burst_len;
    sel_addr = c0_wr_burst_addr;
    case (next_idx)
      2'd0: begin sel_len = c0_wr_burst_len; sel_addr = c0_wr_burst_addr; end
      2'd1: begin sel_len = c0_rd_burst_len; sel_addr = c0_rd_burst_addr; end
      2'd2: begin sel_len = c1_wr_burst_len; sel_addr = c1_wr_burst_addr; end
      default: begin sel_len = c1_rd_burst_len; sel_addr = c1_rd_burst_addr; end
    endcase
  end

  // Only the finish on the granted direction ends a burst; zero-length bursts never engage downstream.
  assign fin_match = (wr_act && wr_burst_finish) || (rd_act && rd_burst_finish);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state           <= IDLE;
      grant_idx       <= 2'd0;
      sts_grant_idx   <= 2'd3;
      len_q           <= '0;
      addr_q          <= '0;
      wdog            <= '0;
      sts_timeout_cnt <= '0;
      wr_act          <= 1'b0;
      rd_act          <= 1'b0;
      zero_fin        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_arb_en && grant_found) begin
            state     <= BUSY;
            grant_idx <= next_idx;
            len_q     <= sel_len;
            addr_q    <= sel_addr;
            wdog      <= '0;
            wr_act    <= (sel_len != 10'd0) && !next_idx[0];
            rd_act    <= (sel_len != 10'd0) &&  next_idx[0];
            zero_fin  <= (sel_len == 10'd0);
          end
        end
        default: begin
          wdog <= wdog + 16'd1;
          if (zero_fin || fin_match || (wdog == TIMEOUT_CYC - 16'd1)) begin
            state         <= IDLE;
            sts_grant_idx <= grant_idx;
            wr_act        <= 1'b0;
            rd_act        <= 1'b0;
            zero_fin      <= 1'b0;
            // Watchdog abort: no client sees a finish, only the status counter moves.
            if (!zero_fin && !fin_match && sts_timeout_cnt != 16'hFFFF)
              sts_timeout_cnt <= sts_timeout_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign sts_busy = (state == BUSY);
  assign hit      = 4'b0001 << grant_idx;

  assign wr_burst_req  = wr_act;
  assign wr_burst_len  = len_q;
  assign wr_burst_addr = addr_q;
  assign wr_burst_data = grant_idx[1] ? c1_wr_burst_data : c0_wr_burst_data;
  assign rd_burst_req  = rd_act;
  assign rd_burst_len  = len_q;
  assign rd_burst_addr = addr_q;

  assign c0_wr_burst_data_req   = wr_act && hit[0] && wr_burst_data_req;
  assign c1_wr_burst_data_req   = wr_act && hit[2] && wr_burst_data_req;
  assign c0_rd_burst_data_valid = rd_act && hit[1] && rd_burst_data_valid;
  assign c1_rd_burst_data_valid = rd_act && hit[3] && rd_burst_data_valid;
  assign c0_rd_burst_data       = rd_burst_data;
  assign c1_rd_burst_data       = rd_burst_data;

  assign c0_wr_burst_finish = hit[0] && ((wr_act && wr_burst_finish) || zero_fin);
  assign c0_rd_burst_finish = hit[1] && ((rd_act && rd_burst_finish) || zero_fin);
  assign c1_wr_burst_finish = hit[2] && ((wr_act && wr_burst_finish) || zero_fin);
  assign c1_rd_burst_finish = hit[3] && ((rd_act && rd_burst_finish) || zero_fin);

endmodule

// File: tb/tb_ddr_burst_arb.sv
// Bench for ddr_burst_arb: randomized bursts checked against a round-robin
// model that tracks only the last served source.
module tb_ddr_burst_arb;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst, cfg_arb_en;
  logic [1:0]    sts_grant_idx;
  logic          sts_busy;
  logic [15:0]   sts_timeout_cnt;
  logic          c0_wr_burst_req, c0_rd_burst_req, c1_wr_burst_req, c1_rd_burst_req;
  logic [9:0]    c0_wr_burst_len, c0_rd_burst_len, c1_wr_burst_len, c1_rd_burst_len;
  logic [AW-1:0] c0_wr_burst_addr, c0_rd_burst_addr, c1_wr_burst_addr, c1_rd_burst_addr;
  logic [DW-1:0] c0_wr_burst_data, c1_wr_burst_data, c0_rd_burst_data, c1_rd_burst_data;
  logic          c0_wr_burst_data_req, c1_wr_burst_data_req, c0_wr_burst_finish, c1_wr_burst_finish;
  logic          c0_rd_burst_data_valid, c1_rd_burst_data_valid, c0_rd_burst_finish, c1_rd_burst_finish;
  logic          wr_burst_req, rd_burst_req, wr_burst_data_req, wr_burst_finish;
  logic          rd_burst_data_valid, rd_burst_finish;
  logic [9:0]    wr_burst_len, rd_burst_len;
  logic [AW-1:0] wr_burst_addr, rd_burst_addr;
  logic [DW-1:0] wr_burst_data, rd_burst_data;

  int checks = 0;
  int failures = 0;
  logic [9:0]    len_tab[4];
  logic [AW-1:0] addr_tab[4];

  ddr_burst_arb #(.DDR_ADDR_WD(AW), .DDR_DATA_WD(DW), .TIMEOUT_CYC(16'd16)) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .cfg_arb_en(cfg_arb_en),
    .sts_grant_idx(sts_grant_idx), .sts_busy(sts_busy), .sts_timeout_cnt(sts_timeout_cnt),
    .c0_wr_burst_req(c0_wr_burst_req), .c0_wr_burst_len(c0_wr_burst_len),
    .c0_wr_burst_addr(c0_wr_burst_addr), .c0_wr_burst_data(c0_wr_burst_data),
    .c0_wr_burst_data_req(c0_wr_burst_data_req), .c0_wr_burst_finish(c0_wr_burst_finish),
    .c0_rd_burst_req(c0_rd_burst_req), .c0_rd_burst_len(c0_rd_burst_len),
    .c0_rd_burst_addr(c0_rd_burst_addr), .c0_rd_burst_data_valid(c0_rd_burst_data_valid),
    .c0_rd_burst_data(c0_rd_burst_data), .c0_rd_burst_finish(c0_rd_burst_finish),
    .c1_wr_burst_req(c1_wr_burst_req), .c1_wr_burst_len(c1_wr_burst_len),
    .c1_wr_burst_addr(c1_wr_burst_addr), .c1_wr_burst_data(c1_wr_burst_data),
    .c1_wr_burst_data_req(c1_wr_burst_data_req), .c1_wr_burst_finish(c1_wr_burst_finish),
    .c1_rd_burst_req(c1_rd_burst_req), .c1_rd_burst_len(c1_rd_burst_len),
    .c1_rd_burst_addr(c1_rd_burst_addr), .c1_rd_burst_data_valid(c1_rd_burst_data_valid),
    .c1_rd_burst_data(c1_rd_burst_data), .c1_rd_burst_finish(c1_rd_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish)
  );

  always #5 ddr_clk = ~ddr_clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge ddr_clk);
    #2;
  endtask

  // Round robin: first requesting source after the last one served.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++)
      if (mask[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
    return last;
  endfunction

  function automatic logic [3:0] fin_vec();
    return {c1_rd_burst_finish, c1_wr_burst_finish, c0_rd_burst_finish, c0_wr_burst_finish};
  endfunction

  function automatic logic [9:0] client_flags();
    return {wr_burst_req, rd_burst_req, c0_wr_burst_data_req, c1_wr_burst_data_req,
            c0_rd_burst_data_valid, c1_rd_burst_data_valid, fin_vec()};
  endfunction

  task automatic clear_inputs();
    {c0_wr_burst_req, c0_rd_burst_req, c1_wr_burst_req, c1_rd_burst_req} = '0;
    {c0_wr_burst_len, c0_rd_burst_len, c1_wr_burst_len, c1_rd_burst_len} = '0;
    {c0_wr_burst_addr, c0_rd_burst_addr, c1_wr_burst_addr, c1_rd_burst_addr} = '0;
    c0_wr_burst_data = '0; c1_wr_burst_data = '0; rd_burst_data = '0;
    wr_burst_data_req = 0; wr_burst_finish = 0; rd_burst_data_valid = 0; rd_burst_finish = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    cfg_arb_en = 1;
    ddr_rst = 1;
    step();
    ddr_rst = 0;
  endtask

  task automatic apply_reqs(input logic [3:0] mask);
    c0_wr_burst_req = mask[0]; c0_wr_burst_len = len_tab[0]; c0_wr_burst_addr = addr_tab[0];
    c0_rd_burst_req = mask[1]; c0_rd_burst_len = len_tab[1]; c0_rd_burst_addr = addr_tab[1];
    c1_wr_burst_req = mask[2]; c1_wr_burst_len = len_tab[2]; c1_wr_burst_addr = addr_tab[2];
    c1_rd_burst_req = mask[3]; c1_rd_burst_len = len_tab[3]; c1_rd_burst_addr = addr_tab[3];
  endtask

  task automatic wait_busy(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      if (sts_busy) begin n = c; break; end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    cfg_arb_en = 1; ddr_rst = 1;
    c0_wr_burst_req = 1; c1_rd_burst_req = 1; c0_wr_burst_len = 10'd3; c1_rd_burst_len = 10'd3;
    step(); step();
    wr_burst_data_req = 1; rd_burst_data_valid = 1; wr_burst_finish = 1; rd_burst_finish = 1;
    #1;
    checks++; if (sts_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", sts_busy); end
    checks++; if (sts_grant_idx !== 2'd3) begin failures++; $display("FAIL reset_grant_idx: got %0d want 3", sts_grant_idx); end
    checks++; if (sts_timeout_cnt !== 16'd0) begin failures++; $display("FAIL reset_timeout_cnt: got %0d want 0", sts_timeout_cnt); end
    checks++; if (client_flags() !== 10'd0) begin failures++; $display("FAIL reset_outputs: got %b want 0", client_flags()); end
    do_reset();
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d0, d1;
    int pulses, gaps;
    do_reset();
    c0_wr_burst_req = 1; c0_wr_burst_len = 10'd8; c0_wr_burst_addr = 32'h100;
    c1_wr_burst_data = {$urandom, $urandom};
    step();
    c0_wr_burst_req = 0;
    checks++; if ({wr_burst_req, rd_burst_req} !== 2'b10) begin failures++; $display("FAIL w1_req: got %b want 10", {wr_burst_req, rd_burst_req}); end
    checks++; if (wr_burst_len !== 10'd8) begin failures++; $display("FAIL w1_len: got %0d want 8", wr_burst_len); end
    checks++; if (wr_burst_addr !== 32'h100) begin failures++; $display("FAIL w1_addr: got %0h want 100", wr_burst_addr); end
    pulses = 0; gaps = 0;
    for (int b = 0; b < 8; b++) begin
      if (gaps < 3 && $urandom_range(0, 1) == 1) begin
        gaps++;
        wr_burst_data_req = 0;
        #1;
        checks++; if ({c0_wr_burst_data_req, c1_wr_burst_data_req} !== 2'b00) begin failures++; $display("FAIL w1_gap: got %b want 00", {c0_wr_burst_data_req, c1_wr_burst_data_req}); end
        step();
      end
      d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      c0_wr_burst_data = d0; c1_wr_burst_data = d1;
      wr_burst_data_req = 1;
      rd_burst_finish = (b == 0);
      #1;
      if (c0_wr_burst_data_req === 1'b1) pulses++;
      checks++; if (c1_wr_burst_data_req !== 1'b0) begin failures++; $display("FAIL w1_c1_leak: got %0b want 0", c1_wr_burst_data_req); end
      checks++; if (wr_burst_data !== d0) begin failures++; $display("FAIL w1_data: got %0h want %0h", wr_burst_data, d0); end
      step();
    end
    wr_burst_data_req = 0; rd_burst_finish = 0;
    checks++; if (pulses !== 8) begin failures++; $display("FAIL w1_pulses: got %0d want 8", pulses); end
    checks++; if (sts_busy !== 1'b1) begin failures++; $display("FAIL w1_still_busy: got %0b want 1", sts_busy); end
    wr_burst_finish = 1;
    #1;
    checks++; if (fin_vec() !== 4'b0001) begin failures++; $display("FAIL w1_finish: got %b want 0001", fin_vec()); end
    step();
    wr_burst_finish = 0;
    checks++; if ({sts_busy, wr_burst_req} !== 2'b00) begin failures++; $display("FAIL w1_idle: got %b want 00", {sts_busy, wr_burst_req}); end
    checks++; if (sts_grant_idx !== 2'd0) begin failures++; $display("FAIL w1_grant_idx: got %0d want 0", sts_grant_idx); end
    wr_burst_finish = 1; rd_burst_finish = 1;
    #1;
    checks++; if (fin_vec() !== 4'b0000) begin failures++; $display("FAIL w1_idle_finish: got %b want 0000", fin_vec()); end
    step();
    wr_burst_finish = 0; rd_burst_finish = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] last, exp;
    logic [3:0] mask;
    logic [AW-1:0] got_addr;
    logic [9:0] got_len;
    int n;
    do_reset();
    last = 2'd3;
    for (int k = 0; k < 4; k++) begin
      len_tab[k] = 10'd4;
      addr_tab[k] = ($urandom & 32'hFFFF_FFF0) | k;
    end
    mask = 4'hF;
    apply_reqs(mask);
    for (int b = 0; b < 11; b++) begin
      if (b >= 5) begin
        mask = 4'($urandom_range(1, 15));
        for (int k = 0; k < 4; k++) begin
          len_tab[k] = 10'($urandom_range(1, 12));
          addr_tab[k] = ($urandom & 32'hFFFF_FFF0) | k;
        end
        apply_reqs(mask);
      end
      exp = rr_pick(last, mask);
      wait_busy(6, n);
      checks++; if (n !== 1) begin failures++; $display("FAIL rr_gap[%0d]: got %0d cycles want 1", b, n); end
      got_addr = exp[0] ? rd_burst_addr : wr_burst_addr;
      got_len  = exp[0] ? rd_burst_len  : wr_burst_len;
      checks++; if ({rd_burst_req, wr_burst_req} !== (exp[0] ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_dir[%0d]: got %b for src %0d", b, {rd_burst_req, wr_burst_req}, exp); end
      checks++; if (got_addr !== addr_tab[exp]) begin failures++; $display("FAIL rr_addr[%0d]: got %0h want %0h", b, got_addr, addr_tab[exp]); end
      checks++; if (got_len !== len_tab[exp]) begin failures++; $display("FAIL rr_len[%0d]: got %0d want %0d", b, got_len, len_tab[exp]); end
      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        step();
        checks++; if ({sts_busy, wr_burst_req & rd_burst_req} !== 2'b10) begin failures++; $display("FAIL rr_hold[%0d]: got %b want 10", b, {sts_busy, wr_burst_req & rd_burst_req}); end
      end
      if (exp[0]) rd_burst_finish = 1; else wr_burst_finish = 1;
      #1;
      checks++; if (fin_vec() !== (4'b0001 << exp)) begin failures++; $display("FAIL rr_finish[%0d]: got %b want %b", b, fin_vec(), 4'b0001 << exp); end
      step();
      rd_burst_finish = 0; wr_burst_finish = 0;
      checks++; if ({sts_busy, sts_grant_idx} !== {1'b0, exp}) begin failures++; $display("FAIL rr_end[%0d]: got busy=%0b idx=%0d want busy=0 idx=%0d", b, sts_busy, sts_grant_idx, exp); end
      last = exp;
    end
    clear_inputs();
  endtask

  task automatic test_read_route();
    logic [DW-1:0] d;
    int valids, gaps;
    do_reset();
    c1_rd_burst_req = 1; c1_rd_burst_len = 10'd4; c1_rd_burst_addr = $urandom;
    step();
    c1_rd_burst_req = 0;
    checks++; if ({wr_burst_req, rd_burst_req, rd_burst_len} !== {2'b01, 10'd4}) begin failures++; $display("FAIL rd_start: got wr=%0b rd=%0b len=%0d", wr_burst_req, rd_burst_req, rd_burst_len); end
    valids = 0; gaps = 0;
    for (int b = 0; b < 4; b++) begin
      if (gaps < 3 && $urandom_range(0, 1) == 1) begin
        gaps++;
        rd_burst_data_valid = 0;
        #1;
        checks++; if ({c0_rd_burst_data_valid, c1_rd_burst_data_valid} !== 2'b00) begin failures++; $display("FAIL rd_gap: got %b want 00", {c0_rd_burst_data_valid, c1_rd_burst_data_valid}); end
        step();
      end
      d = {8{8'hA5}} ^ {$urandom, $urandom};
      rd_burst_data = d; rd_burst_data_valid = 1; wr_burst_data_req = 1;
      #1;
      if (c1_rd_burst_data_valid === 1'b1) valids++;
      checks++; if ({c0_rd_burst_data_valid, c0_wr_burst_data_req, c1_wr_burst_data_req} !== 3'b000) begin failures++; $display("FAIL rd_leak: got %b want 000", {c0_rd_burst_data_valid, c0_wr_burst_data_req, c1_wr_burst_data_req}); end
      checks++; if (c1_rd_burst_data !== d || c0_rd_burst_data !== d) begin failures++; $display("FAIL rd_data: got %0h/%0h want %0h", c0_rd_burst_data, c1_rd_burst_data, d); end
      step();
    end
    rd_burst_data_valid = 0; wr_burst_data_req = 0;
    checks++; if (valids !== 4) begin failures++; $display("FAIL rd_valid_count: got %0d want 4", valids); end
    wr_burst_finish = 1;
    step();
    wr_burst_finish = 0;
    checks++; if (sts_busy !== 1'b1) begin failures++; $display("FAIL rd_wrong_finish: got busy=%0b want 1", sts_busy); end
    rd_burst_finish = 1;
    #1;
    checks++; if (fin_vec() !== 4'b1000) begin failures++; $display("FAIL rd_finish: got %b want 1000", fin_vec()); end
    step();
    rd_burst_finish = 0;
    checks++; if ({sts_busy, sts_grant_idx} !== 3'b011) begin failures++; $display("FAIL rd_end: got busy=%0b idx=%0d want 0/3", sts_busy, sts_grant_idx); end
  endtask

  task automatic test_timeout();
    int busy_cyc, fin_cyc;
    do_reset();
    for (int rep = 1; rep <= 2; rep++) begin
      c0_rd_burst_req = 1; c0_rd_burst_len = 10'($urandom_range(1, 1023)); c0_rd_burst_addr = $urandom;
      step();
      c0_rd_burst_req = 0;
      busy_cyc = 0; fin_cyc = 0;
      for (int c = 0; c < 24; c++) begin
        if (sts_busy === 1'b1) busy_cyc++;
        if (fin_vec() !== 4'b0000) fin_cyc++;
        step();
      end
      checks++; if (busy_cyc !== 16) begin failures++; $display("FAIL to_busy_cycles[%0d]: got %0d want 16", rep, busy_cyc); end
      checks++; if (fin_cyc !== 0) begin failures++; $display("FAIL to_client_finish[%0d]: got %0d want 0", rep, fin_cyc); end
      checks++; if (sts_timeout_cnt !== 16'(rep)) begin failures++; $display("FAIL to_count[%0d]: got %0d want %0d", rep, sts_timeout_cnt, rep); end
      checks++; if (rd_burst_req !== 1'b0) begin failures++; $display("FAIL to_req_drop[%0d]: got %0b want 0", rep, rd_burst_req); end
    end
  endtask

  task automatic test_zero_len();
    logic [1:0] last, src;
    do_reset();
    last = 2'd3;
    for (int r = 0; r < 3; r++) begin
      src = (r == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin len_tab[k] = 10'd0; addr_tab[k] = $urandom; end
      apply_reqs(4'b0001 << src);
      step();
      clear_inputs();
      checks++; if ({wr_burst_req, rd_burst_req} !== 2'b00) begin failures++; $display("FAIL zl_req[%0d]: got %b want 00", r, {wr_burst_req, rd_burst_req}); end
      checks++; if (fin_vec() !== (4'b0001 << src)) begin failures++; $display("FAIL zl_finish[%0d]: got %b want %b", r, fin_vec(), 4'b0001 << src); end
      step();
      checks++; if ({sts_busy, fin_vec()} !== 5'd0) begin failures++; $display("FAIL zl_end[%0d]: got busy=%0b fin=%b want 0", r, sts_busy, fin_vec()); end
      checks++; if (sts_grant_idx !== rr_pick(last, 4'b0001 << src)) begin failures++; $display("FAIL zl_idx[%0d]: got %0d want %0d", r, sts_grant_idx, src); end
      last = src;
    end
  endtask

  task automatic test_arb_en();
    int idle_busy;
    logic [AW-1:0] addr_b;
    do_reset();
    c0_wr_burst_req = 1; c0_wr_burst_len = 10'd6; c0_wr_burst_addr = $urandom;
    step();
    c0_wr_burst_req = 0;
    cfg_arb_en = 0;
    addr_b = $urandom;
    c1_wr_burst_req = 1; c1_wr_burst_len = 10'd3; c1_wr_burst_addr = addr_b;
    step(); step(); step();
    checks++; if ({sts_busy, wr_burst_req} !== 2'b11) begin failures++; $display("FAIL en_no_abort: got %b want 11", {sts_busy, wr_burst_req}); end
    wr_burst_finish = 1;
    #1;
    checks++; if (fin_vec() !== 4'b0001) begin failures++; $display("FAIL en_finish: got %b want 0001", fin_vec()); end
    step();
    wr_burst_finish = 0;
    idle_busy = 0;
    for (int c = 0; c < 8; c++) begin
      if (sts_busy !== 1'b0) idle_busy++;
      step();
    end
    checks++; if (idle_busy !== 0) begin failures++; $display("FAIL en_blocked: got %0d busy cycles want 0", idle_busy); end
    cfg_arb_en = 1;
    step();
    checks++; if ({sts_busy, wr_burst_req, wr_burst_addr, wr_burst_len} !== {2'b11, addr_b, 10'd3}) begin failures++; $display("FAIL en_regrant: got busy=%0b addr=%0h len=%0d want addr=%0h len=3", sts_busy, wr_burst_addr, wr_burst_len, addr_b); end
    step();
    ddr_rst = 1; c1_wr_burst_req = 0;
    step();
    ddr_rst = 0;
    checks++; if (sts_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %0b want 0", sts_busy); end
    checks++; if ({client_flags(), sts_grant_idx} !== {10'd0, 2'd3}) begin failures++; $display("FAIL rst_mid_outputs: got %b idx=%0d want 0 idx=3", client_flags(), sts_grant_idx); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_route();
    test_timeout();
    test_zero_len();
    test_arb_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_burst_arb.md
DDR_BURST_ARB -- requirements
Module: ddr_burst_arb

Interface
REQ-001 Parameters SHALL be:
- DDR_ADDR_WD, default 32, address width.
- DDR_DATA_WD, default 512, data width.
- TIMEOUT_CYC, default 16'hFFFF, watchdog limit in cycles.

REQ-002 Clock and reset SHALL be:
- ddr_clk  in  1  sole clock.
- ddr_rst  in  1  reset; one clock, reset is synchronous and active-high.

REQ-003 Control and status ports SHALL be:
- cfg_arb_en  in  1  level; low blocks new grants.
- sts_grant_idx  out  2  index of last granted source.
- sts_busy  out  1  high while a burst owns the downstream port.
- sts_timeout_cnt  out  16  saturating count of watchdog aborts.

REQ-004 Client write ports, for N = 0 and 1, SHALL be:
- cN_wr_burst_req in 1; cN_wr_burst_len in 10; cN_wr_burst_addr in DDR_ADDR_WD.
- cN_wr_burst_data in DDR_DATA_WD; cN_wr_burst_data_req out 1; cN_wr_burst_finish out 1.

REQ-005 Client read ports, for N = 0 and 1, SHALL be:
- cN_rd_burst_req in 1; cN_rd_burst_len in 10; cN_rd_burst_addr in DDR_ADDR_WD.
- cN_rd_burst_data_valid out 1; cN_rd_burst_data out DDR_DATA_WD; cN_rd_burst_finish out 1.

REQ-006 Downstream ports SHALL be:
- wr_burst_req/len/addr/data out; wr_burst_data_req in; wr_burst_finish in.
- rd_burst_req/len/addr out; rd_burst_data_valid in; rd_burst_data in; rd_burst_finish in.

Function
REQ-007 Source index SHALL be: 0=c0_wr, 1=c0_rd, 2=c1_wr, 3=c1_rd.

REQ-008 FSM states SHALL be IDLE and BUSY.

REQ-009 In IDLE with cfg_arb_en=1 and any request high, at the clock edge the block SHALL:
- grant by round-robin, searching from (sts_grant_idx+1) mod 4;
- latch the grant index, len and addr;
- enter BUSY.

REQ-010 Downstream wr_burst_req SHALL equal BUSY && granted source is a write; rd_burst_req SHALL equal BUSY && granted source is a read.
- Both SHALL first assert one cycle after the granting edge.

REQ-011 Downstream len and addr SHALL come from the latched copies, stable for the whole burst.

REQ-012 Data routing SHALL be:
- wr_burst_data SHALL mux combinationally from the granted client.
- wr_burst_data_req, rd_burst_data_valid and finish SHALL route only to the granted client; all other clients see 0.

REQ-013 cN_rd_burst_data SHALL be driven by rd_burst_data to both clients; it is qualified only by that client's data_valid.

REQ-014 On the matching finish in BUSY, the block SHALL:
- return to IDLE;
- set sts_grant_idx to the granted index.
- Minimum gap between consecutive downstream bursts SHALL be 1 IDLE cycle.

REQ-015 A client dropping its req mid-burst SHALL be ignored; the burst completes.

REQ-016 A finish on the non-granted direction, or any finish in IDLE, SHALL be ignored.

REQ-017 A granted request with len=0 SHALL NOT assert downstream req.
- The arbiter SHALL pulse that client's finish for 1 cycle in the cycle after the grant, then return to IDLE.

REQ-018 Watchdog: a 16-bit counter SHALL clear on grant and increment each BUSY cycle.
- When the counter reaches TIMEOUT_CYC without finish, the block SHALL return to IDLE without a client finish.
- sts_timeout_cnt SHALL increment, saturating at 16'hFFFF.

REQ-019 cfg_arb_en=0 SHALL NOT abort a burst in progress; it only blocks grants in IDLE.

REQ-020 sts_busy SHALL equal (state==BUSY).

Reset
REQ-021 ddr_rst=1 SHALL, on the next edge:
- force IDLE;
- set sts_grant_idx=3 (so c0_wr has first priority);
- clear latched len/addr, watchdog and sts_timeout_cnt.

REQ-022 During and after reset, all req, data_req, data_valid and finish outputs SHALL be 0 until a new grant.

REQ-023 Reset mid-burst SHALL abandon the burst with no client finish.

Verification
REQ-024 Bench SHALL cover these scenarios:
- Reset, then c0_wr req, len=8, addr=0x100 -> wr_burst_req high next cycle, len=8, addr=0x100; 8 data_req pulses reach c0 only; finish -> c0_wr_burst_finish=1, sts_grant_idx=0.
- All four requests held high, each len=4 -> grant order 0,1,2,3,0; exactly one downstream req active at a time.
- c1_rd granted; rd_burst_data_valid x4, pattern 0xA5.. -> c1_rd_burst_data_valid pulses x4, c0_rd_burst_data_valid stays 0.
- TIMEOUT_CYC=16, no finish -> return to IDLE after 16 BUSY cycles, sts_timeout_cnt=1, no client finish.
- c0_wr len=0 -> no downstream req; one-cycle c0_wr_burst_finish.
- cfg_arb_en dropped mid-burst -> burst finishes; no further grant while cfg_arb_en=0; ddr_rst mid-burst -> sts_busy=0 next cycle.
